// File: rtl/keccak_pkg.sv
// keccak_pkg: shared widths, pad bytes and FSM encoding for the absorb loader
package keccak_pkg;
  localparam int LANE_W = 64;
  localparam int RATE_LANES = 17;
  localparam logic [7:0] PAD_DS = 8'h06;
  localparam logic [7:0] PAD_END = 8'h80;
  typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;
endpackage

// File: rtl/keccak_pad_lane.sv
// keccak_pad_lane: masks bytes from nbytes upward and inserts the 0x06/0x80 pad bytes into one lane
module keccak_pad_lane #(
  parameter int LANE_W = keccak_pkg::LANE_W
) (
  input  logic [LANE_W-1:0] lane_in,
  input  logic [3:0]        nbytes,
  input  logic              pad_ds,
  input  logic              pad_end,
  output logic [LANE_W-1:0] lane_out
);
  import keccak_pkg::*;
  localparam int NB = LANE_W / 8;
  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign lane_out[8*b +: 8] = ((pad_ds && 4'(b) >= nbytes) ? 8'h00 : lane_in[8*b +: 8])
      ^ ((pad_ds && 4'(b) == nbytes) ? PAD_DS : 8'h00)
      ^ ((pad_end && b == NB - 1) ? PAD_END : 8'h00);
  end
endmodule

// File: rtl/keccak_absorb_loader.sv
// keccak_absorb_loader: packs message words into padded SHA3 rate blocks with a valid/ready handoff
module keccak_absorb_loader #(
  parameter int LANE_W = keccak_pkg::LANE_W,
  parameter int RATE_LANES = keccak_pkg::RATE_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANE_W-1:0]            din,
  input  logic                         din_valid,
  output logic                         din_ready,
  input  logic                         din_last,
  input  logic [3:0]                   din_nbytes,
  output logic [RATE_LANES*LANE_W-1:0] blk_out,
  output logic                         blk_valid,
  input  logic                         blk_ready,
  output logic                         blk_last,
  output logic                         blk_first
);
  import keccak_pkg::*;
  localparam int CW = $clog2(RATE_LANES + 1);
  localparam logic [CW-1:0] LAST = CW'(RATE_LANES - 1);
  localparam logic [CW-1:0] FULL = CW'(RATE_LANES);
  state_t state;
  logic [CW-1:0] lane_cnt;
  logic pad_tail;
  logic [LANE_W-1:0] lanes [RATE_LANES];
  logic [LANE_W-1:0] padded [RATE_LANES];
  logic [LANE_W-1:0] pad_out;
  keccak_pad_lane #(.LANE_W(LANE_W)) u_pad (
    .lane_in (state == FILL ? din : '0),
    .nbytes  (state == FILL ? din_nbytes : 4'd0),
    .pad_ds  (1'b1),
    .pad_end (lane_cnt == LAST),
    .lane_out(pad_out)
  );
  always_comb begin
    padded = lanes;
    for (int i = 0; i < RATE_LANES; i++)
      padded[i] = CW'(i) == lane_cnt ? pad_out
                : CW'(i) > lane_cnt ? (i == RATE_LANES - 1 ? {PAD_END, {(LANE_W-8){1'b0}}} : '0)
                : lanes[i];
  end
  for (genvar i = 0; i < RATE_LANES; i++) begin : g_out
    assign blk_out[i*LANE_W +: LANE_W] = lanes[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      lane_cnt  <= '0;
      pad_tail  <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_first <= 1'b1;
      din_ready <= 1'b1;
      lanes     <= '{default: '0};
    end else begin
      case (state)
        FILL: if (din_valid) begin
          if (din_last && din_nbytes < 4'd8) begin
            lanes     <= padded;
            blk_last  <= 1'b1;
            blk_valid <= 1'b1;
            din_ready <= 1'b0;
            state     <= EMIT;
          end else begin
            lanes[lane_cnt] <= din;
            lane_cnt        <= lane_cnt + 1'b1;
            if (din_last) begin
              din_ready <= 1'b0;
              state     <= PAD;
            end else if (lane_cnt == LAST) begin
              blk_last  <= 1'b0;
              blk_valid <= 1'b1;
              din_ready <= 1'b0;
              state     <= EMIT;
            end
          end
        end
        PAD: begin
          lanes     <= padded;
          pad_tail  <= lane_cnt == FULL;
          blk_last  <= lane_cnt != FULL;
          blk_valid <= 1'b1;
          state     <= EMIT;
        end
        EMIT: if (blk_ready) begin
          state     <= pad_tail ? PAD : FILL;
          din_ready <= !pad_tail;
          blk_valid <= 1'b0;
          blk_first <= blk_last;
          lane_cnt  <= '0;
          pad_tail  <= 1'b0;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_keccak_absorb_loader.sv
// tb_keccak_absorb_loader: random and directed messages checked against a byte-level SHA3 padding model
module tb_keccak_absorb_loader;
  localparam int LW = 64;
  localparam int RL = 17;
  localparam int BW = LW * RL;
  localparam int RB = RL * 8;
  typedef struct {
    logic [BW-1:0] data;
    logic          first;
    logic          last;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [LW-1:0] din = '0;
  logic din_valid = 1'b0;
  logic din_ready;
  logic din_last = 1'b0;
  logic [3:0] din_nbytes = '0;
  logic [BW-1:0] blk_out;
  logic blk_valid;
  logic blk_ready = 1'b0;
  logic blk_last;
  logic blk_first;
  exp_t exp_q[$];
  exp_t ce;
  logic [63:0] msg [64];
  int errors = 0;
  int checks = 0;
  int nblk = 0;
  logic [BW-1:0] last_out = '0;
  logic last_first = 1'b0;
  logic last_last = 1'b0;
  logic hold_ready = 1'b0;
  logic prev_hold = 1'b0;
  logic [BW-1:0] prev_out = '0;
  logic prev_first = 1'b0;
  logic prev_last = 1'b0;
  keccak_absorb_loader #(.LANE_W(LW), .RATE_LANES(RL)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .din_last(din_last), .din_nbytes(din_nbytes), .blk_out(blk_out), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_last(blk_last), .blk_first(blk_first)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      for (int i = 0; i < RL; i++)
        if (got[64*i +: 64] !== want[64*i +: 64]) begin
          $display("FAIL %s lane %0d: got %h want %h", name, i, got[64*i +: 64], want[64*i +: 64]);
          break;
        end
    end
  endtask
  task automatic chk1(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask
  task automatic model(input int n, input int nb);
    logic [7:0] bq[$];
    exp_t e;
    int nblocks;
    for (int w = 0; w < n; w++)
      for (int b = 0; b < ((w == n - 1) ? nb : 8); b++) bq.push_back(msg[w][8*b +: 8]);
    bq.push_back(8'h06);
    while (bq.size() % RB != 0) bq.push_back(8'h00);
    bq[bq.size() - 1] = bq[bq.size() - 1] ^ 8'h80;
    nblocks = bq.size() / RB;
    for (int k = 0; k < nblocks; k++) begin
      e.data = '0;
      for (int j = 0; j < RB; j++) e.data[8*j +: 8] = bq[k*RB + j];
      e.first = (k == 0);
      e.last = (k == nblocks - 1);
      exp_q.push_back(e);
    end
  endtask
  task automatic send_word(input logic [63:0] w, input logic last, input logic [3:0] nb);
    int t = 0;
    din = w;
    din_last = last;
    din_nbytes = nb;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!din_ready) begin
      checks++;
      errors++;
      $display("FAIL din_ready_timeout: got 0 want 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din_last = 1'($urandom_range(0, 1));
    din_nbytes = 4'($urandom_range(0, 15));
  endtask
  task automatic send_msg(input int n, input int nb, input bit track);
    if (track) model(n, nb);
    for (int w = 0; w < n; w++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send_word(msg[w], w == n - 1, (w == n - 1) ? 4'(nb) : 4'd8);
    end
  endtask
  task automatic wait_drain();
    int t = 0;
    while ((exp_q.size() != 0 || blk_valid) && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending blocks want 0", exp_q.size());
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    blk_ready = !hold_ready && ($urandom_range(0, 3) != 0);
  end
  initial forever begin
    @(negedge clk);
    if (rst) prev_hold = 1'b0;
    else begin
      if (blk_valid) chk1("din_ready_in_emit", din_ready, 1'b0);
      if (prev_hold) begin
        chk1("hold_valid", blk_valid, 1'b1);
        chk("hold_out", blk_out, prev_out);
        chk1("hold_first", blk_first, prev_first);
        chk1("hold_last", blk_last, prev_last);
      end
      if (blk_valid && blk_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_block: got a block want none");
        end else begin
          ce = exp_q.pop_front();
          chk("blk_out", blk_out, ce.data);
          chk1("blk_first", blk_first, ce.first);
          chk1("blk_last", blk_last, ce.last);
        end
        last_out = blk_out;
        last_first = blk_first;
        last_last = blk_last;
        nblk++;
      end
      prev_hold = blk_valid && !blk_ready;
      prev_out = blk_out;
      prev_first = blk_first;
      prev_last = blk_last;
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish within 500000 time units");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [BW-1:0] want;
    logic [BW-1:0] pad_blk;
    logic [BW-1:0] snap;
    int n0;
    int t;
    pad_blk = '0;
    pad_blk[7:0] = 8'h06;
    pad_blk[BW-1 -: 8] = 8'h80;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_blk_valid", blk_valid, 1'b0);
    chk1("rst_din_ready", din_ready, 1'b1);
    chk1("rst_blk_first", blk_first, 1'b1);
    chk1("rst_blk_last", blk_last, 1'b0);
    chk("rst_blk_out", blk_out, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    msg[0] = {$urandom, $urandom};
    send_msg(1, 0, 1);
    wait_drain();
    chk("zero_len_block", last_out, pad_blk);
    chk1("zero_len_first", last_first, 1'b1);
    chk1("zero_len_last", last_last, 1'b1);
    msg[0] = 64'h0000000000636261;
    send_msg(1, 3, 1);
    wait_drain();
    want = '0;
    want[63:0] = 64'h0000000006636261;
    want[BW-1 -: 8] = 8'h80;
    chk("abc_block", last_out, want);
    chk1("abc_first", last_first, 1'b1);
    for (int w = 0; w < 17; w++) msg[w] = {$urandom, $urandom};
    n0 = nblk;
    send_msg(17, 8, 1);
    wait_drain();
    chk("full_rate_blocks", BW'(nblk - n0), BW'(2));
    chk("full_rate_pad_block", last_out, pad_blk);
    chk1("full_rate_pad_first", last_first, 1'b0);
    chk1("full_rate_pad_last", last_last, 1'b1);
    for (int w = 0; w < 16; w++) msg[w] = {$urandom, $urandom};
    msg[16] = 64'hff23456789abcdef;
    n0 = nblk;
    send_msg(17, 7, 1);
    wait_drain();
    chk("pad_86_blocks", BW'(nblk - n0), BW'(1));
    chk("pad_86_lane16", BW'(last_out[BW-1 -: 64]), BW'(64'h8623456789abcdef));
    hold_ready = 1'b1;
    msg[0] = {$urandom, $urandom};
    msg[1] = {$urandom, $urandom};
    send_msg(2, 5, 1);
    t = 0;
    @(negedge clk);
    while (!blk_valid && t < 100) begin
      t++;
      @(negedge clk);
    end
    chk1("hold_reached_emit", blk_valid, 1'b1);
    snap = blk_out;
    repeat (5) begin
      @(posedge clk);
      #1;
      din_valid = 1'b1;
      din = {$urandom, $urandom};
      din_last = 1'b1;
      din_nbytes = 4'd3;
      @(negedge clk);
      chk1("hold_din_ready", din_ready, 1'b0);
      chk1("hold_blk_valid", blk_valid, 1'b1);
      chk("hold_blk_out", blk_out, snap);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    hold_ready = 1'b0;
    wait_drain();
    for (int w = 0; w < 9; w++) msg[w] = {$urandom, $urandom};
    n0 = nblk;
    send_msg(9, 8, 0);
    rst = 1'b1;
    din_valid = 1'b1;
    din_last = 1'b1;
    din_nbytes = 4'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    din_valid = 1'b0;
    @(negedge clk);
    chk1("mid_rst_blk_valid", blk_valid, 1'b0);
    chk1("mid_rst_blk_first", blk_first, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_rst_no_block", BW'(nblk - n0), BW'(0));
    msg[0] = 64'h0000000000636261;
    send_msg(1, 3, 1);
    wait_drain();
    chk("after_rst_block", last_out, want);
    chk1("after_rst_first", last_first, 1'b1);
    repeat (25) begin
      int n;
      n = $urandom_range(1, 40);
      for (int w = 0; w < n; w++) msg[w] = {$urandom, $urandom};
      send_msg(n, $urandom_range(0, 8), 1);
    end
    wait_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
